// File: rtl/mem_access_unit.sv
// Memory-stage responder: issues one req/ack data-bus transaction per aligned load/store,
// stalls the pipeline while it is outstanding, and registers the MEM/WB result.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_moe,
    input  logic        mem_mwr,
    input  logic [31:0] mem_y,
    input  logic [31:0] mem_d,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        dbg_state
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Handshake: bus_req rises the cycle after an access is sampled and stays high
    // with stable addr/we/wdata until the cycle bus_ack=1 or the timeout cycle;
    // bus_rdata is taken only in the ack cycle, and acks outside BUSY are dropped.

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_err_q, wb_err_d;

    logic access;
    logic misaligned;
    logic timed_out;
    logic stall;

    assign access     = mem_valid & (mem_moe | mem_mwr);
    assign misaligned = (mem_y[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        timed_out   = 1'b0;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access && !misaligned) begin
                    stall       = 1'b1;
                    state_d     = ST_BUSY;
                    cnt_d       = 8'd0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_mwr;
                    bus_addr_d  = {mem_y[31:2], 2'b00};
                    bus_wdata_d = mem_d;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    stall = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Retire whenever the pipeline advances; a stalled edge inserts a bubble.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_pc_d    = wb_pc_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;
        if (!stall) begin
            wb_valid_d = mem_valid;
            wb_pc_d    = mem_pc;
            if ((state_q == ST_IDLE && access && misaligned) || timed_out) begin
                wb_err_d  = 1'b1;
                wb_data_d = 32'd0;
            end else if (state_q == ST_BUSY && !bus_we_q) begin
                wb_err_d  = 1'b0;
                wb_data_d = bus_rdata;
            end else begin
                wb_err_d  = 1'b0;
                wb_data_d = mem_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= 32'd0;
            wb_data_q   <= 32'd0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_data_q   <= wb_data_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign mem_stall = stall;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_pc     = wb_pc_q;
    assign wb_data   = wb_data_q;
    assign wb_err    = wb_err_q;
    assign dbg_state = state_q[0];

endmodule
